// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared types and constants for the RV32I load/store unit.
//   lsu_state_e  - FSM state encoding
//   F3_*         - RV32I load/store funct3 encodings
//   lsu_req_bad  - flags an illegal or misaligned request
package riscv_lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LD_REQ    = 3'd1,
    S_LD_DATA   = 3'd2,
    S_RMW_REQ   = 3'd3,
    S_RMW_MERGE = 3'd4,
    S_ST_WR     = 3'd5,
    S_DONE      = 3'd6
  } lsu_state_e;

  // Unsigned loads have no store counterpart, so BU/HU are illegal for stores.
  function automatic logic lsu_req_bad(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic illegal;
    logic misal;
    illegal = 1'b1;
    misal   = 1'b0;
    case (funct3)
      F3_B:  illegal = 1'b0;
      F3_H:  begin illegal = 1'b0;     misal = addr_lo[0];        end
      F3_W:  begin illegal = 1'b0;     misal = (addr_lo != 2'b00); end
      F3_BU: illegal = is_store;
      F3_HU: begin illegal = is_store; misal = addr_lo[0];        end
      default: illegal = 1'b1;
    endcase
    return illegal | misal;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: combinational byte-lane logic for the load/store unit.
//   funct3_i     - access size/sign
//   offset_i     - byte offset within the word (addr[1:0])
//   mem_word_i   - word read from memory
//   wdata_i      - right-justified store data
//   load_data_c  - extracted and extended load result
//   store_word_c - mem_word_i with the addressed lane(s) replaced by store data
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] mem_word_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] store_word_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane extraction followed by sign or zero extension.
  always_comb begin
    byte_sel    = 8'h00;
    half_sel    = offset_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
    load_data_c = mem_word_i;
    case (offset_i)
      2'd0:    byte_sel = mem_word_i[7:0];
      2'd1:    byte_sel = mem_word_i[15:8];
      2'd2:    byte_sel = mem_word_i[23:16];
      default: byte_sel = mem_word_i[31:24];
    endcase
    case (funct3_i)
      F3_B:    load_data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_c = {24'h000000, byte_sel};
      F3_H:    load_data_c = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_c = {16'h0000, half_sel};
      default: load_data_c = mem_word_i;
    endcase
  end

  // Read-modify-write merge; a full word simply replaces the memory word.
  always_comb begin
    store_word_c = mem_word_i;
    case (funct3_i)
      F3_B: begin
        case (offset_i)
          2'd0:    store_word_c[7:0]   = wdata_i[7:0];
          2'd1:    store_word_c[15:8]  = wdata_i[7:0];
          2'd2:    store_word_c[23:16] = wdata_i[7:0];
          default: store_word_c[31:24] = wdata_i[7:0];
        endcase
      end
      F3_H: begin
        if (offset_i[1]) store_word_c[31:16] = wdata_i[15:0];
        else             store_word_c[15:0]  = wdata_i[15:0];
      end
      default: store_word_c = wdata_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: multi-cycle RV32I load/store unit on a word-wide memory with
// 1-cycle synchronous read and no byte enables (sub-word stores use RMW).
//   clk, rst               - clock, synchronous active-high reset
//   start, is_store,
//   funct3, addr, wdata    - request, sampled only while idle
//   busy, done, err, rdata - status and load result
//   dAddress, MemRead,
//   MemWrite, dWriteData,
//   dReadData              - memory interface
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned PRINT_LSU_TRANSACTIONS = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] dAddress,
  output logic            MemRead,
  output logic            MemWrite,
  output logic [XLEN-1:0] dWriteData,
  input  logic [XLEN-1:0] dReadData
);

  lsu_state_e      state_q, state_d;
  logic            is_store_q, is_store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_d;
  logic            busy_q, done_q, err_q, mem_read_q, mem_write_q;
  logic [XLEN-1:0] d_address_q, d_write_data_q;
  logic [XLEN-1:0] write_word_d;
  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] store_word_c;

  riscv_lsu_align u_align (
    .funct3_i     (funct3_q),
    .offset_i     (addr_q[1:0]),
    .mem_word_i   (dReadData),
    .wdata_i      (wdata_q),
    .load_data_c  (load_data_c),
    .store_word_c (store_word_c)
  );

  // Next-state, request latch and result update.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          addr_d     = addr;
          wdata_d    = wdata;
          if (lsu_req_bad(is_store, funct3, addr[1:0])) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (!is_store) begin
            state_d = S_LD_REQ;
          end else if (funct3 == F3_W) begin
            state_d = S_ST_WR;
          end else begin
            state_d = S_RMW_REQ;
          end
        end
      end
      S_LD_REQ:    state_d = S_LD_DATA;
      S_LD_DATA: begin
        rdata_d = load_data_c;
        state_d = S_DONE;
      end
      S_RMW_REQ:   state_d = S_RMW_MERGE;
      S_RMW_MERGE: state_d = S_ST_WR;
      S_ST_WR:     state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // A full-word store goes straight from IDLE, so take the live wdata input.
  assign write_word_d = (state_q == S_IDLE) ? wdata : store_word_c;

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      is_store_q     <= 1'b0;
      funct3_q       <= 3'b000;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      d_address_q    <= '0;
      d_write_data_q <= '0;
    end else begin
      state_q        <= state_d;
      is_store_q     <= is_store_d;
      funct3_q       <= funct3_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rdata_q        <= rdata_d;
      busy_q         <= (state_d != S_IDLE);
      done_q         <= (state_d == S_DONE);
      err_q          <= err_d;
      mem_read_q     <= (state_d == S_LD_REQ) || (state_d == S_RMW_REQ);
      mem_write_q    <= (state_d == S_ST_WR) && is_store_d;
      d_address_q    <= (state_d != S_IDLE) ? {addr_d[XLEN-1:2], 2'b00} : '0;
      d_write_data_q <= (state_d == S_ST_WR) ? write_word_d : '0;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign dAddress   = d_address_q;
  assign dWriteData = d_write_data_q;

`ifndef SYNTHESIS
  // Optional transaction trace, printed in the cycle done is high.
  if (PRINT_LSU_TRANSACTIONS != 0) begin : g_print
    always @(posedge clk) begin
      if (done_q) begin
        $display("%0t lsu %s addr=%h data=%h err=%b", $time,
                 is_store_q ? "st" : "ld", addr_q,
                 is_store_q ? wdata_q : rdata_q, err_q);
      end
    end
  end
`endif

endmodule
